reorder_buffer: RTL and testbench

Circular reorder buffer between the Dispatcher and the register file (RF) in the out-of-order core. It allocates entries in program order at issue and captures results from the common data bus (CDB). It retires one entry per cycle in order, driving the RF commit port (`RoB_update_*`). On a branch mispredict it raises `flush_signal` and a redirect PC for the whole pipeline. It also answers operand-readiness queries from the Dispatcher, with same-cycle CDB bypass.

---
 rtl/reorder_buffer.sv | 187 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 585 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate and retire, CDB capture,
// mispredict flush with redirect PC, and operand queries with CDB bypass.
module reorder_buffer #(
   parameter int         RoB_WIDTH = 3,
   parameter logic [5:0] NON_DEP   = 6'b100000
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 issue_en,
   input  logic [5:0]           issue_rd,
   input  logic                 issue_is_br,
   input  logic                 issue_pred,
   input  logic [31:0]          issue_pc,
   output logic [RoB_WIDTH-1:0] issue_index,
   output logic                 full,
   input  logic                 wb_en,
   input  logic [RoB_WIDTH-1:0] wb_index,
   input  logic [31:0]          wb_data,
   input  logic                 wb_taken,
   input  logic [31:0]          wb_target,
   input  logic [RoB_WIDTH-1:0] q1_index,
   input  logic [RoB_WIDTH-1:0] q2_index,
   output logic                 q1_ready,
   output logic                 q2_ready,
   output logic [31:0]          q1_data,
   output logic [31:0]          q2_data,
   output logic                 RoB_update_en,
   output logic [5:0]           RoB_update_reg,
   output logic [RoB_WIDTH-1:0] RoB_update_index,
   output logic [31:0]          RoB_update_data,
   output logic                 flush_signal,
   output logic [31:0]          flush_pc
);

   localparam int                   DEPTH    = 1 << RoB_WIDTH;
   localparam logic [RoB_WIDTH:0]   CNT_FULL = (RoB_WIDTH+1)'(DEPTH);
   localparam logic [RoB_WIDTH:0]   CNT_ONE  = (RoB_WIDTH+1)'(1);
   localparam logic [RoB_WIDTH-1:0] PTR_ONE  = RoB_WIDTH'(1);

   logic [RoB_WIDTH-1:0] r_head;
   logic [RoB_WIDTH-1:0] r_tail;
   logic [RoB_WIDTH:0]   r_count;
   logic [DEPTH-1:0]     r_busy;
   logic [DEPTH-1:0]     r_ready;
   logic [DEPTH-1:0]     r_is_br;
   logic [DEPTH-1:0]     r_pred;
   logic [DEPTH-1:0]     r_taken;
   logic [5:0]           r_rd     [DEPTH];
   logic [31:0]          r_data   [DEPTH];
   logic [31:0]          r_target [DEPTH];
   logic [31:0]          r_pc     [DEPTH];

   logic                 r_upd_en;
   logic [5:0]           r_upd_reg;
   logic [RoB_WIDTH-1:0] r_upd_index;
   logic [31:0]          r_upd_data;
   logic                 r_flush;
   logic [31:0]          r_flush_pc;

   logic                 w_full;
   logic                 w_head_go;
   logic                 w_mispred;
   logic                 w_commit;
   logic                 w_issue;
   logic                 w_wb;
   logic [31:0]          w_flush_pc;

   // Head is only judged on state already registered; a same-cycle
   // writeback never makes the head retire early.
   assign w_full     = (r_count == CNT_FULL);
   assign w_head_go  = r_busy[r_head] & r_ready[r_head] & ~r_flush;
   assign w_mispred  = w_head_go & r_is_br[r_head]
                     & (r_taken[r_head] ^ r_pred[r_head]);
   assign w_commit   = w_head_go & ~w_mispred;
   assign w_issue    = issue_en & ~w_full & ~r_flush & ~w_mispred;
   assign w_wb       = wb_en & r_busy[wb_index] & ~r_flush & ~w_mispred;
   assign w_flush_pc = r_taken[r_head] ? r_target[r_head]
                                       : r_pc[r_head] + 32'd4;

   assign issue_index      = r_tail;
   assign full             = w_full;
   assign RoB_update_en    = r_upd_en;
   assign RoB_update_reg   = r_upd_reg;
   assign RoB_update_index = r_upd_index;
   assign RoB_update_data  = r_upd_data;
   assign flush_signal     = r_flush;
   assign flush_pc         = r_flush_pc;

   // Pointer, occupancy and per-entry bookkeeping
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_busy  <= '0;
         r_ready <= '0;
         r_is_br <= '0;
         r_pred  <= '0;
         r_taken <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_rd[i]     <= NON_DEP;
            r_data[i]   <= '0;
            r_target[i] <= '0;
            r_pc[i]     <= '0;
         end
      end else if (rdy_in) begin
         if (w_mispred) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
         end else begin
            if (w_wb) begin
               r_ready[wb_index]  <= 1'b1;
               r_data[wb_index]   <= wb_data;
               r_taken[wb_index]  <= wb_taken;
               r_target[wb_index] <= wb_target;
            end
            if (w_commit) begin
               r_busy[r_head] <= 1'b0;
               r_head         <= r_head + PTR_ONE;
            end
            if (w_issue) begin
               r_busy[r_tail]  <= 1'b1;
               r_ready[r_tail] <= 1'b0;
               r_rd[r_tail]    <= issue_rd;
               r_is_br[r_tail] <= issue_is_br;
               r_pred[r_tail]  <= issue_pred;
               r_pc[r_tail]    <= issue_pc;
               r_tail          <= r_tail + PTR_ONE;
            end
            if (w_issue & ~w_commit) begin
               r_count <= r_count + CNT_ONE;
            end else if (~w_issue & w_commit) begin
               r_count <= r_count - CNT_ONE;
            end
         end
      end
   end

   // Registered commit pulse to the RF and flush pulse to the pipeline
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_upd_en    <= 1'b0;
         r_upd_reg   <= '0;
         r_upd_index <= '0;
         r_upd_data  <= '0;
         r_flush     <= 1'b0;
         r_flush_pc  <= '0;
      end else if (rdy_in) begin
         r_upd_en <= w_commit;
         r_flush  <= w_mispred;
         if (w_commit) begin
            r_upd_reg   <= r_rd[r_head];
            r_upd_index <= r_head;
            r_upd_data  <= r_data[r_head];
         end
         if (w_mispred) begin
            r_flush_pc <= w_flush_pc;
         end
      end
   end

   // Operand queries: stored value first, then same-cycle CDB bypass
   always_comb begin
      q1_ready = 1'b0;
      q1_data  = '0;
      q2_ready = 1'b0;
      q2_data  = '0;
      if (r_busy[q1_index] & r_ready[q1_index]) begin
         q1_ready = 1'b1;
         q1_data  = r_data[q1_index];
      end else if (wb_en && (wb_index == q1_index)) begin
         q1_ready = 1'b1;
         q1_data  = wb_data;
      end
      if (r_busy[q2_index] & r_ready[q2_index]) begin
         q2_ready = 1'b1;
         q2_data  = r_data[q2_index];
      end else if (wb_en && (wb_index == q2_index)) begin
         q2_ready = 1'b1;
         q2_data  = wb_data;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus a randomized run
// against a queue-based model of in-order retirement.
module tb_reorder_buffer;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        issue_en = 1'b0;
   logic [5:0]  issue_rd = '0;
   logic        issue_is_br = 1'b0;
   logic        issue_pred = 1'b0;
   logic [31:0] issue_pc = '0;
   logic [2:0]  issue_index;
   logic        full;
   logic        wb_en = 1'b0;
   logic [2:0]  wb_index = '0;
   logic [31:0] wb_data = '0;
   logic        wb_taken = 1'b0;
   logic [31:0] wb_target = '0;
   logic [2:0]  q1_index = '0;
   logic [2:0]  q2_index = '0;
   logic        q1_ready, q2_ready;
   logic [31:0] q1_data, q2_data;
   logic        RoB_update_en;
   logic [5:0]  RoB_update_reg;
   logic [2:0]  RoB_update_index;
   logic [31:0] RoB_update_data;
   logic        flush_signal;
   logic [31:0] flush_pc;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   reorder_buffer dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .issue_en(issue_en), .issue_rd(issue_rd),
      .issue_is_br(issue_is_br), .issue_pred(issue_pred),
      .issue_pc(issue_pc), .issue_index(issue_index), .full(full),
      .wb_en(wb_en), .wb_index(wb_index), .wb_data(wb_data),
      .wb_taken(wb_taken), .wb_target(wb_target),
      .q1_index(q1_index), .q2_index(q2_index),
      .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_data(q1_data), .q2_data(q2_data),
      .RoB_update_en(RoB_update_en), .RoB_update_reg(RoB_update_reg),
      .RoB_update_index(RoB_update_index),
      .RoB_update_data(RoB_update_data),
      .flush_signal(flush_signal), .flush_pc(flush_pc)
   );

   // Model: program-ordered list of live instructions
   typedef struct {
      int          idx;
      logic [5:0]  rd;
      logic [31:0] data;
      bit          done;
      bit          br;
      bit          pred;
      bit          taken;
      logic [31:0] tgt;
      logic [31:0] pc;
   } ent_t;

   ent_t        mq[$];
   int          m_tail = 0;
   bit          m_flush = 0;
   bit          e_en = 0;
   logic [5:0]  e_reg = '0;
   int          e_idx = 0;
   logic [31:0] e_data = '0;
   logic [31:0] e_fpc = '0;

   task automatic model_reset();
      mq.delete();
      m_tail = 0;
      m_flush = 0;
      e_en = 0;
      e_fpc = '0;
   endtask

   task automatic model_step();
      bit   was_full;
      ent_t h;
      ent_t n;
      if (!rdy_in) return;
      if (m_flush) begin
         m_flush = 0;
         e_en = 0;
         return;
      end
      was_full = (mq.size() == 8);
      e_en = 0;
      if (mq.size() > 0 && mq[0].done) begin
         h = mq[0];
         if (h.br && h.taken != h.pred) begin
            m_flush = 1;
            e_fpc = h.taken ? h.tgt : h.pc + 32'd4;
            mq.delete();
            m_tail = 0;
            return;
         end
         e_en = 1;
         e_reg = h.rd;
         e_idx = h.idx;
         e_data = h.data;
         void'(mq.pop_front());
      end
      if (wb_en) begin
         foreach (mq[k]) begin
            if (mq[k].idx == int'(wb_index)) begin
               mq[k].done = 1;
               mq[k].data = wb_data;
               mq[k].taken = wb_taken;
               mq[k].tgt = wb_target;
            end
         end
      end
      if (issue_en && !was_full) begin
         n.idx = m_tail;
         n.rd = issue_rd;
         n.data = '0;
         n.done = 0;
         n.br = issue_is_br;
         n.pred = issue_pred;
         n.taken = 0;
         n.tgt = '0;
         n.pc = issue_pc;
         mq.push_back(n);
         m_tail = (m_tail + 1) % 8;
      end
   endtask

   function automatic logic [32:0] mquery(input logic [2:0] qi);
      foreach (mq[k]) begin
         if (mq[k].idx == int'(qi) && mq[k].done) return {1'b1, mq[k].data};
      end
      if (wb_en && wb_index == qi) return {1'b1, wb_data};
      return 33'd0;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle();
      issue_en = 0;
      issue_is_br = 0;
      issue_pred = 0;
      wb_en = 0;
      wb_taken = 0;
      rdy_in = 1;
   endtask

   task automatic do_reset();
      idle();
      rst_in = 1;
      model_reset();
      @(posedge clk_in);
      #1;
      rst_in = 0;
   endtask

   task automatic issue1(input logic [5:0] rd, input logic br,
                         input logic pr, input logic [31:0] pc);
      issue_en = 1;
      issue_rd = rd;
      issue_is_br = br;
      issue_pred = pr;
      issue_pc = pc;
      tick();
      issue_en = 0;
   endtask

   task automatic wb1(input logic [2:0] idx, input logic [31:0] d,
                      input logic tk, input logic [31:0] tg);
      wb_en = 1;
      wb_index = idx;
      wb_data = d;
      wb_taken = tk;
      wb_target = tg;
      tick();
      wb_en = 0;
   endtask

   task automatic test_reset();
      logic [78:0] got;
      idle();
      rst_in = 1;
      model_reset();
      #2;
      got = {RoB_update_en, RoB_update_reg, RoB_update_index,
             RoB_update_data, flush_signal, flush_pc, issue_index, full};
      n_checks++;
      if (got !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want 0", got);
      end
      n_checks++;
      if (q1_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_query: got %b want 0", q1_ready);
      end
      @(posedge clk_in);
      #1;
      rst_in = 0;
   endtask

   task automatic test_inorder();
      logic [31:0] ed [3];
      ed[0] = 32'h00;
      ed[1] = 32'h11;
      ed[2] = 32'h22;
      do_reset();
      issue1(6'd5, 0, 0, 32'h10);
      issue1(6'd6, 0, 0, 32'h14);
      issue1(6'd7, 0, 0, 32'h18);
      n_checks++;
      if (issue_index !== 3'd3) begin
         n_err++;
         $display("FAIL inorder_tail: got %0d want 3", issue_index);
      end
      wb1(3'd2, 32'h22, 0, 0);
      wb1(3'd0, 32'h00, 0, 0);
      wb1(3'd1, 32'h11, 0, 0);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if ({RoB_update_en, RoB_update_index, RoB_update_reg,
              RoB_update_data} !==
             {1'b1, 3'(k), 6'(5 + k), ed[k]}) begin
            n_err++;
            $display("FAIL inorder_commit%0d: got en=%b idx=%0d rd=%0d d=%h want en=1 idx=%0d rd=%0d d=%h",
                     k, RoB_update_en, RoB_update_index, RoB_update_reg,
                     RoB_update_data, k, 5 + k, ed[k]);
         end
         tick();
      end
      n_checks++;
      if (RoB_update_en !== 1'b0) begin
         n_err++;
         $display("FAIL inorder_drop: got %b want 0", RoB_update_en);
      end
   endtask

   task automatic test_full();
      int         got[$];
      int         cyc[$];
      logic [5:0] last_reg;
      last_reg = '0;
      do_reset();
      for (int k = 0; k < 8; k++) issue1(6'(k + 1), 0, 0, 32'(k * 4));
      n_checks++;
      if ({full, issue_index} !== {1'b1, 3'd0}) begin
         n_err++;
         $display("FAIL full_set: got full=%b idx=%0d want full=1 idx=0",
                  full, issue_index);
      end
      issue1(6'd9, 0, 0, 32'h99);
      n_checks++;
      if ({full, issue_index} !== {1'b1, 3'd0}) begin
         n_err++;
         $display("FAIL full_ignore: got full=%b idx=%0d want full=1 idx=0",
                  full, issue_index);
      end
      wb1(3'd0, 32'h55, 0, 0);
      n_checks++;
      if ({full, RoB_update_en} !== 2'b10) begin
         n_err++;
         $display("FAIL full_before_commit: got full=%b en=%b want full=1 en=0",
                  full, RoB_update_en);
      end
      tick();
      n_checks++;
      if ({full, RoB_update_en, RoB_update_index, RoB_update_data} !==
          {1'b0, 1'b1, 3'd0, 32'h55}) begin
         n_err++;
         $display("FAIL full_drop: got full=%b en=%b idx=%0d d=%h want full=0 en=1 idx=0 d=55",
                  full, RoB_update_en, RoB_update_index, RoB_update_data);
      end
      issue1(6'd20, 0, 0, 32'h200);
      n_checks++;
      if ({full, issue_index} !== {1'b1, 3'd1}) begin
         n_err++;
         $display("FAIL full_wrap_issue: got full=%b idx=%0d want full=1 idx=1",
                  full, issue_index);
      end
      for (int k = 0; k < 11; k++) begin
         if (k < 8) begin
            wb_en = 1;
            wb_index = 3'((k + 1) % 8);
            wb_data = 32'(k);
            wb_taken = 0;
         end else begin
            wb_en = 0;
         end
         tick();
         if (RoB_update_en) begin
            got.push_back(int'(RoB_update_index));
            cyc.push_back(k);
            last_reg = RoB_update_reg;
         end
      end
      wb_en = 0;
      n_checks++;
      if (got.size() != 8) begin
         n_err++;
         $display("FAIL wrap_count: got %0d want 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (got[i] != (i + 1) % 8) begin
               n_err++;
               $display("FAIL wrap_order%0d: got %0d want %0d",
                        i, got[i], (i + 1) % 8);
            end
         end
         n_checks++;
         if (cyc[7] - cyc[0] != 7) begin
            n_err++;
            $display("FAIL wrap_bubble: got span %0d want 7",
                     cyc[7] - cyc[0]);
         end
         n_checks++;
         if (last_reg !== 6'd20) begin
            n_err++;
            $display("FAIL wrap_last_rd: got %0d want 20", last_reg);
         end
      end
   endtask

   task automatic test_mispredict();
      do_reset();
      issue1(6'd1, 1, 0, 32'h100);
      issue1(6'd2, 0, 0, 32'h104);
      issue1(6'd3, 0, 0, 32'h108);
      wb1(3'd1, 32'hAA, 0, 0);
      wb1(3'd2, 32'hBB, 0, 0);
      wb1(3'd0, 32'h0, 1, 32'h200);
      issue_en = 1;
      issue_rd = 6'd4;
      tick();
      n_checks++;
      if ({flush_signal, flush_pc, RoB_update_en} !==
          {1'b1, 32'h200, 1'b0}) begin
         n_err++;
         $display("FAIL mis_taken: got fl=%b pc=%h en=%b want fl=1 pc=200 en=0",
                  flush_signal, flush_pc, RoB_update_en);
      end
      tick();
      issue_en = 0;
      n_checks++;
      if ({flush_signal, RoB_update_en, issue_index, full} !==
          {1'b0, 1'b0, 3'd0, 1'b0}) begin
         n_err++;
         $display("FAIL mis_after: got fl=%b en=%b idx=%0d full=%b want 0 0 0 0",
                  flush_signal, RoB_update_en, issue_index, full);
      end
      tick();
      tick();
      n_checks++;
      if (RoB_update_en !== 1'b0) begin
         n_err++;
         $display("FAIL mis_discard: got en=%b want 0", RoB_update_en);
      end
      for (int k = 0; k < 7; k++) issue1(6'(k), 0, 0, 32'h0);
      n_checks++;
      if (full !== 1'b0) begin
         n_err++;
         $display("FAIL mis_count7: got full=%b want 0", full);
      end
      issue1(6'd7, 0, 0, 32'h0);
      n_checks++;
      if (full !== 1'b1) begin
         n_err++;
         $display("FAIL mis_count8: got full=%b want 1", full);
      end
      do_reset();
      issue1(6'd1, 1, 1, 32'h100);
      wb1(3'd0, 32'h0, 0, 32'h300);
      tick();
      n_checks++;
      if ({flush_signal, flush_pc, RoB_update_en} !==
          {1'b1, 32'h104, 1'b0}) begin
         n_err++;
         $display("FAIL mis_nottaken: got fl=%b pc=%h en=%b want fl=1 pc=104 en=0",
                  flush_signal, flush_pc, RoB_update_en);
      end
   endtask

   task automatic test_query();
      do_reset();
      for (int k = 0; k < 4; k++) issue1(6'(k), 0, 0, 32'h0);
      wb_en = 1;
      wb_index = 3'd3;
      wb_data = 32'hDEAD;
      wb_taken = 0;
      q1_index = 3'd3;
      q2_index = 3'd2;
      #1;
      n_checks++;
      if ({q1_ready, q1_data} !== {1'b1, 32'hDEAD}) begin
         n_err++;
         $display("FAIL query_bypass: got r=%b d=%h want r=1 d=dead",
                  q1_ready, q1_data);
      end
      n_checks++;
      if ({q2_ready, q2_data} !== 33'd0) begin
         n_err++;
         $display("FAIL query_notready: got r=%b d=%h want r=0 d=0",
                  q2_ready, q2_data);
      end
      tick();
      wb_en = 0;
      #1;
      n_checks++;
      if ({q1_ready, q1_data, RoB_update_en} !==
          {1'b1, 32'hDEAD, 1'b0}) begin
         n_err++;
         $display("FAIL query_stored: got r=%b d=%h en=%b want r=1 d=dead en=0",
                  q1_ready, q1_data, RoB_update_en);
      end
   endtask

   task automatic test_pause();
      do_reset();
      issue1(6'd10, 0, 0, 32'h0);
      issue1(6'd11, 0, 0, 32'h4);
      wb1(3'd0, 32'h70, 0, 0);
      wb1(3'd1, 32'h71, 0, 0);
      rdy_in = 0;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if ({RoB_update_en, RoB_update_index, RoB_update_reg,
              RoB_update_data} !== {1'b1, 3'd0, 6'd10, 32'h70}) begin
            n_err++;
            $display("FAIL pause_hold%0d: got en=%b idx=%0d d=%h want en=1 idx=0 d=70",
                     k, RoB_update_en, RoB_update_index, RoB_update_data);
         end
         if (k < 3) tick();
      end
      rdy_in = 1;
      tick();
      n_checks++;
      if ({RoB_update_en, RoB_update_index, RoB_update_data} !==
          {1'b1, 3'd1, 32'h71}) begin
         n_err++;
         $display("FAIL pause_resume: got en=%b idx=%0d d=%h want en=1 idx=1 d=71",
                  RoB_update_en, RoB_update_index, RoB_update_data);
      end
      tick();
      n_checks++;
      if (RoB_update_en !== 1'b0) begin
         n_err++;
         $display("FAIL pause_end: got en=%b want 0", RoB_update_en);
      end
   endtask

   task automatic test_async_reset();
      logic [78:0] got;
      do_reset();
      for (int k = 0; k < 5; k++) issue1(6'(k + 1), 0, 0, 32'h0);
      wb1(3'd0, 32'h1, 0, 0);
      tick();
      n_checks++;
      if (RoB_update_en !== 1'b1) begin
         n_err++;
         $display("FAIL areset_pre: got en=%b want 1", RoB_update_en);
      end
      #3;
      rst_in = 1;
      model_reset();
      #1;
      got = {RoB_update_en, RoB_update_reg, RoB_update_index,
             RoB_update_data, flush_signal, flush_pc, issue_index, full};
      n_checks++;
      if (got !== '0) begin
         n_err++;
         $display("FAIL areset_outputs: got %h want 0", got);
      end
      #2;
      rst_in = 0;
      tick();
      tick();
      n_checks++;
      if ({RoB_update_en, issue_index} !== 4'd0) begin
         n_err++;
         $display("FAIL areset_after: got en=%b idx=%0d want en=0 idx=0",
                  RoB_update_en, issue_index);
      end
   endtask

   task automatic test_random();
      logic [32:0] exp_q;
      int          k;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rdy_in = ($urandom_range(0, 9) != 0);
         issue_en = $urandom_range(0, 1);
         issue_rd = 6'($urandom_range(0, 32));
         issue_is_br = ($urandom_range(0, 7) == 0);
         issue_pred = $urandom_range(0, 1);
         issue_pc = $urandom & 32'hFFFF_FFFC;
         wb_en = ($urandom_range(0, 2) != 0);
         if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
            k = $urandom_range(0, mq.size() - 1);
            wb_index = 3'(mq[k].idx);
         end else begin
            wb_index = 3'($urandom_range(0, 7));
         end
         wb_data = $urandom;
         wb_taken = $urandom_range(0, 1);
         wb_target = $urandom;
         q1_index = 3'($urandom_range(0, 7));
         q2_index = 3'($urandom_range(0, 7));
         #1;
         exp_q = mquery(q1_index);
         n_checks++;
         if ({q1_ready, q1_data} !== exp_q) begin
            n_err++;
            $display("FAIL rnd_q1 c%0d: got %b/%h want %b/%h", c,
                     q1_ready, q1_data, exp_q[32], exp_q[31:0]);
         end
         exp_q = mquery(q2_index);
         n_checks++;
         if ({q2_ready, q2_data} !== exp_q) begin
            n_err++;
            $display("FAIL rnd_q2 c%0d: got %b/%h want %b/%h", c,
                     q2_ready, q2_data, exp_q[32], exp_q[31:0]);
         end
         tick();
         n_checks++;
         if ({RoB_update_en, flush_signal} !== {e_en, m_flush}) begin
            n_err++;
            $display("FAIL rnd_pulse c%0d: got en=%b fl=%b want en=%b fl=%b",
                     c, RoB_update_en, flush_signal, e_en, m_flush);
         end
         if (e_en) begin
            n_checks++;
            if ({RoB_update_index, RoB_update_reg, RoB_update_data} !==
                {3'(e_idx), e_reg, e_data}) begin
               n_err++;
               $display("FAIL rnd_commit c%0d: got idx=%0d rd=%0d d=%h want idx=%0d rd=%0d d=%h",
                        c, RoB_update_index, RoB_update_reg, RoB_update_data,
                        e_idx, e_reg, e_data);
            end
         end
         if (m_flush) begin
            n_checks++;
            if (flush_pc !== e_fpc) begin
               n_err++;
               $display("FAIL rnd_fpc c%0d: got %h want %h", c, flush_pc, e_fpc);
            end
         end
         n_checks++;
         if ({full, issue_index} !== {mq.size() == 8, 3'(m_tail)}) begin
            n_err++;
            $display("FAIL rnd_occ c%0d: got full=%b idx=%0d want full=%b idx=%0d",
                     c, full, issue_index, mq.size() == 8, m_tail);
         end
      end
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_inorder();
      test_full();
      test_mispredict();
      test_query();
      test_pause();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
